uart_cmd_ctrl: RTL and testbench

- Command sequencer behind the UART receiver in the sensor/stopwatch/watch design.
- Consumes received bytes (8-bit data plus a 1-cycle done strobe), parses short ASCII command frames, and issues single-cycle command pulses with an optional decimal argument to the stopwatch, watch and sensor controllers.
- Rejects malformed frames with an error pulse and resynchronises on the next frame.

---
 rtl/uart_cmd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Command sequencer behind the UART receiver. Parses ASCII frames of the form
// CMD [D1 D0] TERM and issues one-cycle command pulses with an optional
// decimal argument. Malformed frames produce a one-cycle error pulse.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_data    received byte, valid only while rx_done=1
//   rx_done    one-cycle strobe marking a new byte
//   cmd_valid  one-cycle pulse, cmd_code/cmd_arg valid
//   cmd_code   0=RUN_STOP 1=CLEAR 2=MODE 3=SENSOR 4=SET_HOUR 5=SET_MIN 6=SET_SEC
//   cmd_arg    binary argument (0 for no-argument commands), held until next cmd_valid
//   cmd_err    one-cycle pulse, frame rejected
//   busy       high while a frame is partially received
//
// Optional build macro: UART_CMD_TIMEOUT_EN
//   When defined, a partial frame that sees no byte for TIMEOUT_CYC cycles
//   is discarded with an error pulse.
module uart_cmd_ctrl #(
  parameter int ARG_MAX     = 59,
  parameter int TIMEOUT_CYC = 10_000_000,
  parameter int TO_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [6:0] cmd_arg,
  output logic       cmd_err,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARG_HI = 3'd1;
  localparam logic [2:0] ARG_LO = 3'd2;
  localparam logic [2:0] TERM   = 3'd3;
  localparam logic [2:0] ISSUE  = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  logic [2:0] state;
  logic [2:0] code_q;
  logic [3:0] tens_q;
  logic [3:0] units_q;
  // Delays an IDLE-state rejection by one cycle so it lines up with the
  // ERR-state path timing.
  logic       idle_err;

  logic       is_cmd;
  logic       is_set;
  logic [2:0] byte_code;
  logic       is_digit;
  logic       is_term;
  logic [6:0] arg_sum;
  logic       timeout_hit;

  always_comb begin
    is_cmd    = 1'b1;
    is_set    = 1'b0;
    byte_code = 3'd0;
    case (rx_data)
      8'h52:   byte_code = 3'd0;
      8'h43:   byte_code = 3'd1;
      8'h4D:   byte_code = 3'd2;
      8'h53:   byte_code = 3'd3;
      8'h68:   begin byte_code = 3'd4; is_set = 1'b1; end
      8'h6D:   begin byte_code = 3'd5; is_set = 1'b1; end
      8'h73:   begin byte_code = 3'd6; is_set = 1'b1; end
      default: is_cmd = 1'b0;
    endcase
  end

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  // Max 9*10+9 = 99 fits in 7 bits.
  assign arg_sum  = ({3'b000, tens_q} * 7'd10) + {3'b000, units_q};
  assign busy     = (state != IDLE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting     = (state == ARG_HI) || (state == ARG_LO) || (state == TERM);
  assign timeout_hit = waiting && (to_cnt == TO_LAST);

  // Counts idle cycles inside a frame; restarts on each accepted byte and
  // saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!waiting || rx_done) begin
      to_cnt <= '0;
    end else if (to_cnt != {TO_W{1'b1}}) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // No timeout in this build; the expression is constant 0 but keeps the
  // timeout parameters part of the shared interface.
  assign timeout_hit = (TO_W == 0) && (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      code_q    <= 3'd0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      idle_err  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      cmd_arg   <= 7'd0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= idle_err;
      idle_err  <= 1'b0;
      case (state)
        IDLE: begin
          // CR/LF between frames is silently skipped.
          if (rx_done) begin
            if (is_cmd) begin
              code_q  <= byte_code;
              tens_q  <= 4'd0;
              units_q <= 4'd0;
              state   <= is_set ? ARG_HI : TERM;
            end else if (!is_term) begin
              idle_err <= 1'b1;
            end
          end
        end
        ARG_HI: begin
          if (rx_done) begin
            if (is_digit) begin
              tens_q <= rx_data[3:0];
              state  <= ARG_LO;
            end else begin
              state <= ERR;
            end
          end else if (timeout_hit) begin
            state <= ERR;
          end
        end
        ARG_LO: begin
          if (rx_done) begin
            if (is_digit) begin
              units_q <= rx_data[3:0];
              state   <= TERM;
            end else begin
              state <= ERR;
            end
          end else if (timeout_hit) begin
            state <= ERR;
          end
        end
        TERM: begin
          if (rx_done) begin
            state <= is_term ? ISSUE : ERR;
          end else if (timeout_hit) begin
            state <= ERR;
          end
        end
        ISSUE: begin
          if (arg_sum <= 7'(ARG_MAX)) begin
            cmd_valid <= 1'b1;
            cmd_code  <= code_q;
            cmd_arg   <= arg_sum;
          end else begin
            cmd_err <= 1'b1;
          end
          state <= IDLE;
        end
        ERR: begin
          cmd_err <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
// Directed bench for uart_cmd_ctrl. Expected command/error pulses are queued
// when the terminating byte is sampled and matched (kind, code, arg, time)
// when the design pulses.
module tb_uart_cmd_ctrl;

  localparam int TO_CYC = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [6:0] cmd_arg;
  logic       cmd_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [2:0] code;
    logic [6:0] arg;
    longint     t;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   got;
  int     total = 0;
  int     bad = 0;
  longint t_last = 0;

  uart_cmd_ctrl #(
    .ARG_MAX(59),
    .TIMEOUT_CYC(TO_CYC),
    .TO_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_arg(cmd_arg),
    .cmd_err(cmd_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 = no output expected, 1 = cmd_valid, 2 = cmd_err.
  // A pulse is expected in the cycle after the edge following the sampling edge,
  // observed at the negedge 15 time units after the sampling posedge.
  task automatic applyStimulus(input logic [7:0] b, input int kind,
                               input logic [2:0] code = 3'd0, input logic [6:0] arg = 7'd0);
    exp_t e;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    t_last = longint'($time);
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.code   = code;
      e.arg    = arg;
      e.t      = t_last + 15;
      exp_q.push_back(e);
    end
    #1;
    rx_done = 1'b0;
    rx_data = 8'h52;
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (cmd_valid || cmd_err)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, cmd_valid, cmd_err}, 32'd0);
      end else begin
        got = exp_q.pop_front();
        checkOutput("pulse_time", 32'($time), 32'(got.t));
        checkOutput("pulse_kind", {30'd0, cmd_valid, cmd_err}, got.is_err ? 32'd1 : 32'd2);
        if (!got.is_err) begin
          checkOutput("cmd_code", {29'd0, cmd_code}, {29'd0, got.code});
          checkOutput("cmd_arg", {25'd0, cmd_arg}, {25'd0, got.arg});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, cmd_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_code", {29'd0, cmd_code}, 32'd0);
    checkOutput("rst_arg", {25'd0, cmd_arg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame aborts silently.
    applyStimulus("h", 0);
    applyStimulus("1", 0);
    checkOutput("busy_partial", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("midrst_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("R", 0);
    applyStimulus(8'h0A, 1, 3'd0, 7'd0);

    // Set command, outputs hold afterwards.
    applyStimulus("m", 0);
    applyStimulus("4", 0);
    applyStimulus("5", 0);
    applyStimulus(8'h0D, 1, 3'd5, 7'd45);
    repeat (3) @(negedge clk);
    checkOutput("hold_code", {29'd0, cmd_code}, 32'd5);
    checkOutput("hold_arg", {25'd0, cmd_arg}, 32'd45);

    // Range boundary.
    applyStimulus("s", 0);
    applyStimulus("5", 0);
    applyStimulus("9", 0);
    applyStimulus(8'h0A, 1, 3'd6, 7'd59);
    applyStimulus("s", 0);
    applyStimulus("6", 0);
    applyStimulus("0", 0);
    applyStimulus(8'h0A, 2);
    repeat (2) @(negedge clk);
    checkOutput("over_arg_hold", {25'd0, cmd_arg}, 32'd59);

    // Malformed frames.
    applyStimulus("h", 0);
    applyStimulus("x", 2);
    checkOutput("idle_after_err", {31'd0, busy}, 32'd0);
    applyStimulus("C", 0);
    applyStimulus("C", 2);
    applyStimulus("Z", 2);
    applyStimulus("C", 0);
    applyStimulus(8'h0D, 1, 3'd1, 7'd0);

    // CRLF handling.
    applyStimulus("M", 0);
    applyStimulus(8'h0D, 1, 3'd2, 7'd0);
    applyStimulus(8'h0A, 0);
    applyStimulus("S", 0);
    applyStimulus(8'h0A, 1, 3'd3, 7'd0);

    // Long gap inside a frame.
    applyStimulus("h", 0);
    applyStimulus("1", 0);
`ifdef UART_CMD_TIMEOUT_EN
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.code   = 3'd0;
      e.arg    = 7'd0;
      e.t      = t_last + longint'(TO_CYC) * 10 + 15;
      exp_q.push_back(e);
    end
    repeat (TO_CYC + 5) @(negedge clk);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
`else
    repeat (TO_CYC + 5) @(negedge clk);
    checkOutput("gap_busy", {31'd0, busy}, 32'd1);
    applyStimulus("2", 0);
    applyStimulus(8'h0D, 1, 3'd4, 7'd12);
`endif

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
